// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states and default line timing
// at a 50 MHz system clock. Also used by the receive controller.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_RELEASE,
    ST_SHIFT,
    ST_ACK
  } ps2_tx_state_t;

  localparam int PS2_INHIBIT_CYC = 5000;    // 100 us clock-low inhibit
  localparam int PS2_REQ_CYC     = 10;      // both lines low before clock release
  localparam int PS2_TIMEOUT_CYC = 750000;  // 15 ms between device clock falls

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for an asynchronous PS/2 line with a one-cycle
// falling-edge pulse. Lines idle high, so all flops reset to 1.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      prev_reg <= 1'b1;
    end else begin
      meta_reg <= line;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign fall = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, then
// shifts data/parity/stop on device clock falls and checks the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = PS2_INHIBIT_CYC,
  parameter int REQ_CYC     = PS2_REQ_CYC,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC
) (
  input  logic       clock_50,
  input  logic       res,
  input  logic [7:0] tx_data,
  input  logic       tx_strb,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int MAX_A   = (INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC;
  localparam int MAX_CYC = (TIMEOUT_CYC > MAX_A) ? TIMEOUT_CYC : MAX_A;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] REQ_LAST     = CNT_W'(REQ_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  ps2_tx_state_t    state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       bit_reg, bit_next;
  logic [7:0]       data_reg, data_next;
  logic             par_reg, par_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic             clk_oe_reg, clk_oe_next;
  logic             dat_oe_reg, dat_oe_next;
  logic             dat_meta_reg, dat_sync_reg;
  logic             clk_fall;
  logic [8:0]       tx_bits;

  ps2_sync_edge u_clk_sync (
    .clk   (clock_50),
    .rst_n (res),
    .line  (ps2_clk_in),
    .fall  (clk_fall)
  );

  always_ff @(posedge clock_50 or negedge res) begin
    if (!res) begin
      dat_meta_reg <= 1'b1;
      dat_sync_reg <= 1'b1;
    end else begin
      dat_meta_reg <= ps2_dat_in;
      dat_sync_reg <= dat_meta_reg;
    end
  end

  assign tx_bits = {par_reg, data_reg};

  always_ff @(posedge clock_50 or negedge res) begin
    if (!res) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      bit_reg    <= '0;
      data_reg   <= '0;
      par_reg    <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      clk_oe_reg <= 1'b0;
      dat_oe_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bit_reg    <= bit_next;
      data_reg   <= data_next;
      par_reg    <= par_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      clk_oe_reg <= clk_oe_next;
      dat_oe_reg <= dat_oe_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bit_next    = bit_reg;
    data_next   = data_reg;
    par_next    = par_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    clk_oe_next = 1'b0;
    dat_oe_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (tx_strb) begin
          data_next  = tx_data;
          par_next   = odd_parity(tx_data);
          cnt_next   = '0;
          bit_next   = '0;
          state_next = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_reg == INHIBIT_LAST) begin
          cnt_next   = '0;
          state_next = ST_REQ;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_REQ: begin
        if (cnt_reg == REQ_LAST) begin
          cnt_next   = '0;
          state_next = ST_RELEASE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RELEASE, ST_SHIFT, ST_ACK: begin
        // A fall on the terminal count still counts as a live device.
        if (clk_fall) begin
          cnt_next = '0;
          case (state_reg)
            ST_RELEASE: begin
              state_next = ST_SHIFT;
              bit_next   = 4'd0;
            end
            ST_SHIFT: begin
              bit_next = bit_reg + 4'd1;
              if (bit_reg == 4'd8) state_next = ST_ACK;
            end
            default: begin
              state_next = ST_IDLE;
              done_next  = ~dat_sync_reg;
              err_next   = dat_sync_reg;
            end
          endcase
        end else if (cnt_reg == TIMEOUT_LAST) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Line drivers are registered decodes of the next state; ACK holds the
    // stop bit, i.e. data released.
    case (state_next)
      ST_INHIBIT: clk_oe_next = 1'b1;
      ST_REQ: begin
        clk_oe_next = 1'b1;
        dat_oe_next = 1'b1;
      end
      ST_RELEASE: dat_oe_next = 1'b1;
      ST_SHIFT:   dat_oe_next = ~tx_bits[bit_next];
      default: ;
    endcase
  end

  assign tx_busy    = (state_reg != ST_IDLE);
  assign tx_done    = done_reg;
  assign tx_err     = err_reg;
  assign ps2_clk_oe = clk_oe_reg;
  assign ps2_dat_oe = dat_oe_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: table of command frames against a
// simple open-drain PS/2 device model, plus timeout/reset/ignore sequences.
module tb_ps2_host_tx;

  localparam int INH  = 5000;
  localparam int RQ   = 10;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic       clock_50 = 1'b0;
  logic       res;
  logic [7:0] tx_data;
  logic       tx_strb;
  logic       tx_busy, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk, dev_dat;
  logic       clk_line, dat_line;

  assign clk_line = dev_clk & ~ps2_clk_oe;
  assign dat_line = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYC (INH),
    .REQ_CYC     (RQ),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clock_50   (clock_50),
    .res        (res),
    .tx_data    (tx_data),
    .tx_strb    (tx_strb),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 clock_50 = ~clock_50;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [9:0] obs;
  int inh_n, req_n, d0, e0, n;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic [9:0] exp_bits;  // {stop, parity, data} as seen on the data line
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  always @(negedge clock_50) begin
    if (res) begin
      if (tx_done) done_cnt++;
      if (tx_err) err_cnt++;
      if (tx_done || tx_err) chk("busy_at_pulse", tx_busy, 0);
      if (tx_done || tx_err) chk("done_err_excl", {tx_done, tx_err} == 2'b11, 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  task automatic send_strobe(input logic [7:0] d);
    @(negedge clock_50);
    tx_data = d;
    tx_strb = 1'b1;
    @(negedge clock_50);
    tx_strb = 1'b0;
  endtask

  // Counts inhibit and request cycles, ending on the first RELEASE sample.
  task automatic host_req(output int inh, output int req);
    inh = 0;
    req = 0;
    while (ps2_clk_oe && !ps2_dat_oe && inh < 20000) begin
      inh++;
      @(negedge clock_50);
    end
    while (ps2_clk_oe && ps2_dat_oe && req < 20000) begin
      req++;
      @(negedge clock_50);
    end
  endtask

  task automatic dev_bit(input int idx);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clock_50);
    if (idx < 10) obs[idx] = dat_line;
    dev_clk = 1'b1;
    repeat (HALF) @(negedge clock_50);
  endtask

  task automatic dev_ack(input logic ack);
    repeat (5) @(negedge clock_50);
    dev_dat = ack ? 1'b0 : 1'b1;
    repeat (5) @(negedge clock_50);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clock_50);
    dev_clk = 1'b1;
    repeat (HALF) @(negedge clock_50);
    dev_dat = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] d, input logic ack, input logic [9:0] exp_bits,
                           input logic exp_done, input logic exp_err, input int inject_at,
                           input string tag);
    int inh, req, dc, ec;
    dc = done_cnt;
    ec = err_cnt;
    send_strobe(d);
    host_req(inh, req);
    chk({tag, "_inhibit"}, inh, INH);
    chk({tag, "_req"}, req, RQ);
    chk({tag, "_start"}, {ps2_clk_oe, ps2_dat_oe}, 2'b01);
    repeat (30) @(negedge clock_50);
    obs = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == inject_at) begin
        tx_data = 8'hAA;
        tx_strb = 1'b1;
        @(negedge clock_50);
        tx_strb = 1'b0;
        chk({tag, "_busy_mid"}, tx_busy, 1);
      end
      dev_bit(i);
    end
    dev_ack(ack);
    repeat (10) @(negedge clock_50);
    chk({tag, "_bits"}, obs, exp_bits);
    chk({tag, "_parity"}, obs[8], exp_bits[8]);
    chk({tag, "_done"}, done_cnt - dc, exp_done);
    chk({tag, "_err"}, err_cnt - ec, exp_err);
    chk({tag, "_idle"}, {tx_busy, ps2_clk_oe, ps2_dat_oe}, 3'b000);
    $display("frame %s data=%02h ack=%0b bits=%03h done=%0d err=%0d", tag, d, ack, obs,
             done_cnt - dc, err_cnt - ec);
  endtask

  initial begin
    res = 1'b0;
    tx_strb = 1'b0;
    tx_data = 8'h00;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (3) @(negedge clock_50);
    chk("rst_outputs", {tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe}, 5'b00000);
    $display("reset busy=%0b done=%0b err=%0b clk_oe=%0b dat_oe=%0b", tx_busy, tx_done, tx_err,
             ps2_clk_oe, ps2_dat_oe);
    res = 1'b1;
    repeat (5) @(negedge clock_50);

    vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 10'h3FF, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 10'h300, 1'b1, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 10'h201, 1'b1, 1'b0};
    vecs[4] = '{8'h5A, 1'b0, 10'h35A, 1'b0, 1'b1};
    for (int v = 0; v < 5; v++)
      run_frame(vecs[v].data, vecs[v].ack, vecs[v].exp_bits, vecs[v].exp_done,
                vecs[v].exp_err, -1, $sformatf("vec%0d", v));

    // Strobe with a different byte during SHIFT must not disturb the frame.
    run_frame(8'hED, 1'b1, 10'h3ED, 1'b1, 1'b0, 4, "strb_in_shift");

    // Silent device: error exactly TMO cycles after RELEASE entry.
    d0 = done_cnt;
    e0 = err_cnt;
    send_strobe(8'h12);
    host_req(inh_n, req_n);
    n = 0;
    while (!tx_err && n < 3 * TMO) begin
      @(negedge clock_50);
      n++;
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_lines", {tx_busy, ps2_clk_oe, ps2_dat_oe}, 3'b000);
    repeat (5) @(negedge clock_50);
    chk("tmo_err_cnt", err_cnt - e0, 1);
    chk("tmo_no_done", done_cnt - d0, 0);
    $display("timeout data=12 cycles=%0d err=%0d", n, err_cnt - e0);

    // Reset after the fifth fall, while bit 4 (0) of 8'hED is driven.
    d0 = done_cnt;
    e0 = err_cnt;
    send_strobe(8'hED);
    host_req(inh_n, req_n);
    repeat (30) @(negedge clock_50);
    for (int i = 0; i < 5; i++) dev_bit(i);
    chk("mid_dat_oe", ps2_dat_oe, 1);
    #2 res = 1'b0;
    #1 chk("mid_rst_lines", {tx_busy, ps2_clk_oe, ps2_dat_oe}, 3'b000);
    repeat (3) @(negedge clock_50);
    res = 1'b1;
    repeat (200) @(negedge clock_50);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_no_err", err_cnt - e0, 0);
    chk("mid_rst_idle", {tx_busy, ps2_clk_oe, ps2_dat_oe}, 3'b000);
    $display("midframe_reset done=%0d err=%0d", done_cnt - d0, err_cnt - e0);
    run_frame(8'hED, 1'b1, 10'h3ED, 1'b1, 1'b0, -1, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 5000: clock-low inhibit length in clock_50 cycles (100 us).
REQ-002 SHALL have parameter REQ_CYC, default 10: cycles with both lines held low before clock release.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 750000: maximum cycles between device clock falling edges (15 ms).
REQ-004 SHALL have port clock_50  input  1  sole clock, 50 MHz.
REQ-005 SHALL have port res  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tx_data  input  8  command byte to send to keyboard.
REQ-007 SHALL have port tx_strb  input  1  one-cycle request; tx_data sampled on the same edge.
REQ-008 SHALL have port tx_busy  output  1  high from accepted request until done or error.
REQ-009 SHALL have port tx_done  output  1  one-cycle pulse when device ACK is received.
REQ-010 SHALL have port tx_err  output  1  one-cycle pulse on timeout or missing ACK.
REQ-011 SHALL have port ps2_clk_in  input  1  raw PS/2 clock line, asynchronous.
REQ-012 SHALL have port ps2_dat_in  input  1  raw PS/2 data line, asynchronous.
REQ-013 SHALL have port ps2_clk_oe  output  1  1 = pull clock line low (open-drain); 0 = release.
REQ-014 SHALL have port ps2_dat_oe  output  1  1 = pull data line low (open-drain); 0 = release.

Function
REQ-015 SHALL synchronise ps2_clk_in and ps2_dat_in through two flops; falling-edge detection on the synchronised clock sets fall for one cycle.
REQ-016 SHALL implement states IDLE, INHIBIT, REQ, RELEASE, SHIFT, ACK.
REQ-017 IDLE: clk_oe=0, dat_oe=0, busy=0; tx_strb latches tx_data, computes odd parity (~^tx_data), clears counters, goes INHIBIT.
REQ-018 SHALL ignore tx_strb while tx_busy=1.
REQ-019 INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYC cycles, then REQ.
REQ-020 REQ: clk_oe=1, dat_oe=1 (start bit) for exactly REQ_CYC cycles, then RELEASE.
REQ-021 RELEASE: clk_oe=0, dat_oe=1; first fall moves to SHIFT with bit index 0 driven.
REQ-022 SHIFT: on each fall, drive in turn data bits 0..7 (LSB first), then parity, then stop; dat_oe = inverse of the bit value; stop releases data (dat_oe=0).
REQ-023 SHALL change dat_oe only in the cycle after a fall, never at other times.
REQ-024 ACK: on next fall after stop, sampled data=0 -> tx_done pulse; data=1 -> tx_err pulse; either returns to IDLE.
REQ-025 Total falls per frame SHALL be 11 (8 data, parity, stop, ACK); 4-bit bit counter.
REQ-026 Timeout counter SHALL clear on entry to RELEASE and on every fall; reaching TIMEOUT_CYC in RELEASE, SHIFT or ACK -> tx_err pulse, both oe released, IDLE.
REQ-027 tx_busy SHALL fall in the same cycle tx_done or tx_err pulses; a new tx_strb is accepted the following cycle.
REQ-028 tx_done and tx_err SHALL never assert together.
REQ-029 Fall coincident with timeout terminal count: fall wins, counter clears.

Reset
REQ-030 res low SHALL immediately force IDLE, ps2_clk_oe=0, ps2_dat_oe=0, tx_busy=0, tx_done=0, tx_err=0, counters and sync flops to idle-high/zero, regardless of state.
REQ-031 Reset mid-frame SHALL not produce tx_done or tx_err on release.

Structure
REQ-032 Shared package ps2_pkg SHALL hold the state enum and PS/2 timing constants (INHIBIT_CYC, REQ_CYC, TIMEOUT_CYC defaults) for reuse by ps2ctrlr.
REQ-033 Sub-module ps2_sync_edge (two-flop sync plus falling-edge pulse) SHALL be instantiated for the clock line; data uses its sync path only.
REQ-034 Top level SHALL gate ps2ctrlr reception with tx_busy; that wiring is outside this block.

Verification
REQ-035 tx_data=8'hED, device model ACKs -> clk_oe low 5000 cycles, then both low 10 cycles, bits 1,0,1,1,0,1,1,1, parity 1, stop released, tx_done pulse, busy low.
REQ-036 tx_data=8'hFF -> parity bit 1 driven (dat_oe=0 at falling edge 9); tx_data=8'h00 -> parity 1; tx_data=8'h01 -> parity 0.
REQ-037 Device holds data high at ACK fall -> tx_err pulse, no tx_done, both oe=0.
REQ-038 Device never clocks after release -> tx_err exactly TIMEOUT_CYC cycles after RELEASE entry.
REQ-039 res asserted after fall 5 -> oe outputs 0 same cycle; after release no pulses; next tx_strb runs full frame.
REQ-040 tx_strb pulsed during SHIFT with 8'hAA -> ignored, original byte completes unchanged.
